lc3_fetch_unit: RTL and testbench
=================================

// Module: lc3_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the LC-3 controller FSM.
//  - Owns the PC and issues 16-bit reads to instruction memory over a req/gnt/rvalid interface.
//  - Presents the fetched word, plus the incremented PC, to decode via a valid/ready handshake.
//  - Replaces the controller's FETCH0..FETCH2 sequencing; the controller redirects it on BR/JMP/JSR.
// PARAMETERS
//  ADDR_W    16       address and PC width
//  DATA_W    16       instruction width
//  RESET_PC  16'h3000 PC value after reset
//  TIMEOUT   16       cycles to wait for mem_rvalid before error (used only with LC3_FETCH_TIMEOUT_EN)
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst_n        in   1       synchronous, active-low reset
//  mem_req      out  1       read request, held until mem_gnt
//  mem_addr     out  ADDR_W  read address (= PC); valid while mem_req=1
//  mem_gnt      in   1       request accepted this cycle
//  mem_rvalid   in   1       read data valid; exactly one per granted request, >=1 cycle after gnt
//  mem_rdata    in   DATA_W  read data
//  ir_valid     out  1       fetched instruction available
//  ir           out  DATA_W  fetched instruction
//  ir_pc        out  ADDR_W  PC+1 of the fetched instruction (LC-3 PC-relative base)
//  ir_ready     in   1       decode accepts ir this cycle
//  redirect     in   1       load new PC (branch/jump/JSR taken)
//  redirect_pc  in   ADDR_W  target PC
//  fetch_err    out  1       memory timeout (sticky); constant 0 without the macro
// BEHAVIOUR
//  - All outputs registered. Reset: state=F_IDLE, pc=RESET_PC (mem_addr=RESET_PC), mem_req=0,
//    ir_valid=0, ir=0, ir_pc=0, fetch_err=0, timeout counter=0.
//  - States: F_IDLE, F_REQ, F_WAIT, F_HOLD, F_DRAIN, F_ERR.
//  - F_IDLE: one bubble cycle after reset, then F_REQ with mem_req=1.
//  - F_REQ: mem_req=1. On mem_gnt: pc<=pc+1 (mod 2^ADDR_W; 16'hFFFF wraps to 0), mem_req<=0, go F_WAIT.
//  - F_WAIT: on mem_rvalid: ir<=mem_rdata, ir_pc<=pc, ir_valid<=1, go F_HOLD.
//  - F_HOLD: ir/ir_pc stable while ir_valid=1 and ir_ready=0. On ir_ready: ir_valid<=0, mem_req<=1, go F_REQ.
//  - Latency: gnt in cycle N, rvalid in N+1 -> ir_valid=1 in N+2. Next mem_req=1 the cycle after the handshake.
//  - mem_gnt outside F_REQ and mem_rvalid outside F_WAIT/F_DRAIN are ignored.
//  - redirect has priority over every event in every state except F_ERR. It sets pc<=redirect_pc, ir_valid<=0, mem_req<=0.
//    Next state after redirect:
//    * Request outstanding (F_WAIT without rvalid, or F_REQ with gnt the same cycle): F_DRAIN.
//    * Otherwise: F_REQ; mem_req=1, mem_addr=redirect_pc the next cycle.
//    * redirect with rvalid in F_WAIT: data discarded, go F_REQ.
//    * redirect with ir_ready in F_HOLD: the instruction counts as delivered, go F_REQ.
//  - F_DRAIN: the next mem_rvalid is discarded, then go F_REQ. redirect in F_DRAIN updates pc and
//    stays in F_DRAIN, unless rvalid arrives the same cycle, in which case go F_REQ.
//  - At most one outstanding memory request at any time.
// CONFIGURATION
//  LC3_FETCH_TIMEOUT_EN defined:
//   - Counter clears on entry to F_WAIT/F_DRAIN and increments each cycle there without mem_rvalid.
//   - When it reaches TIMEOUT: fetch_err<=1, mem_req<=0, ir_valid<=0, go F_ERR.
//   - F_ERR: absorbing; redirect and mem_rvalid ignored; only rst_n exits.
//  LC3_FETCH_TIMEOUT_EN undefined:
//   - No counter and no F_ERR; F_WAIT/F_DRAIN wait indefinitely; fetch_err tied to 0.
// TESTING
//  - Reset: rst_n=0 for 2 cycles -> mem_req=0, ir_valid=0, mem_addr=16'h3000; first mem_req=1 on the
//    2nd cycle after release.
//  - Basic fetch: gnt at once, rvalid next cycle with rdata=16'h1261, ir_ready=1 -> ir=16'h1261,
//    ir_pc=16'h3001, ir_valid 2 cycles after gnt; next mem_addr=16'h3001.
//  - Backpressure: ir_ready=0 for 5 cycles -> ir/ir_pc stable, mem_req=0 throughout; ready=1 ->
//    mem_req=1 the next cycle.
//  - Redirect while outstanding: redirect_pc=16'h4000 in F_WAIT, rvalid 3 cycles later with
//    16'hDEAD -> 16'hDEAD never on ir; next mem_addr=16'h4000.
//  - Wrap: redirect_pc=16'hFFFF, fetch -> ir_pc=16'h0000, next mem_addr=16'h0000.
//  - Timeout (macro on, TIMEOUT=16): gnt with no rvalid -> fetch_err=1 after 16 waiting cycles;
//    later rvalid/redirect ignored until reset. Macro off: no error, completes on a late rvalid.

Source files
------------

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch: owns the PC, reads memory over req/gnt/rvalid and hands words to decode via valid/ready.
// gnt in N, rvalid in N+1 -> ir_valid in N+2; `LC3_FETCH_TIMEOUT_EN adds a sticky memory-timeout error state.
module lc3_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h3000,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_err
);

  typedef enum logic [2:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD, F_DRAIN, F_ERR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              req_n, vld_n;
  logic [DATA_W-1:0] ir_n;
  logic [ADDR_W-1:0] ir_pc_n;

  assign mem_addr = pc;

`ifdef LC3_FETCH_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_n;
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = mem_req;
    vld_n   = ir_valid;
    ir_n    = ir;
    ir_pc_n = ir_pc;
`ifdef LC3_FETCH_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = fetch_err;
`endif
    case (state)
      F_IDLE: begin
        req_n   = 1'b1;
        state_n = F_REQ;
        if (redirect) pc_n = redirect_pc;
      end
      F_REQ: begin
        if (redirect) begin
          pc_n  = redirect_pc;
          vld_n = 1'b0;
          // A grant in the same cycle still owes us one rvalid, so it must be drained.
          if (mem_gnt) begin
            req_n   = 1'b0;
            state_n = F_DRAIN;
`ifdef LC3_FETCH_TIMEOUT_EN
            cnt_n   = '0;
`endif
          end else begin
            req_n   = 1'b1;
          end
        end else if (mem_gnt) begin
          pc_n    = pc + ADDR_W'(1);
          req_n   = 1'b0;
          state_n = F_WAIT;
`ifdef LC3_FETCH_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      F_WAIT: begin
        if (mem_rvalid) begin
          if (redirect) begin
            pc_n    = redirect_pc;
            vld_n   = 1'b0;
            req_n   = 1'b1;
            state_n = F_REQ;
          end else begin
            ir_n    = mem_rdata;
            ir_pc_n = pc;
            vld_n   = 1'b1;
            state_n = F_HOLD;
          end
        end else if (redirect) begin
          pc_n    = redirect_pc;
          vld_n   = 1'b0;
          req_n   = 1'b0;
          state_n = F_DRAIN;
`ifdef LC3_FETCH_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end else begin
`ifdef LC3_FETCH_TIMEOUT_EN
          if (cnt == CNT_LAST) begin
            err_n   = 1'b1;
            req_n   = 1'b0;
            vld_n   = 1'b0;
            state_n = F_ERR;
          end else begin
            cnt_n   = cnt + CNT_W'(1);
          end
`endif
        end
      end
      F_HOLD: begin
        if (redirect || ir_ready) begin
          vld_n   = 1'b0;
          req_n   = 1'b1;
          state_n = F_REQ;
          if (redirect) pc_n = redirect_pc;
        end
      end
      F_DRAIN: begin
        if (redirect) begin
          pc_n  = redirect_pc;
          vld_n = 1'b0;
        end
        if (mem_rvalid) begin
          req_n   = 1'b1;
          state_n = F_REQ;
        end else begin
`ifdef LC3_FETCH_TIMEOUT_EN
          if (cnt == CNT_LAST) begin
            err_n   = 1'b1;
            req_n   = 1'b0;
            vld_n   = 1'b0;
            state_n = F_ERR;
          end else begin
            cnt_n   = cnt + CNT_W'(1);
          end
`endif
        end
      end
`ifdef LC3_FETCH_TIMEOUT_EN
      F_ERR: state_n = F_ERR;
`endif
      default: state_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= F_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
`ifdef LC3_FETCH_TIMEOUT_EN
      cnt      <= '0;
      fetch_err <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      mem_req  <= req_n;
      ir_valid <= vld_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
`ifdef LC3_FETCH_TIMEOUT_EN
      cnt      <= cnt_n;
      fetch_err <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Bench for lc3_fetch_unit: directed scenarios followed by randomized traffic against a transaction-level model.
module tb_lc3_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; ir_ready = 0; redirect = 0; redirect_pc = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (mem_addr !== 16'h3000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=3000", mem_addr); end
    checks++; if (ir !== 16'h0000 || ir_pc !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h/%h exp=0000/0000", ir, ir_pc); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
    rst_n = 1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin errors++; $display("FAIL reset_first_req got=%b@%h exp=1@3000", mem_req, mem_addr); end
  endtask

  task automatic test_basic_fetch;
    mem_gnt = 1; tick();
    mem_gnt = 0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop got=%b exp=0", mem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", ir_valid); end
    mem_rvalid = 1; mem_rdata = 16'h1261; ir_ready = 1; tick();
    mem_rvalid = 0;
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_ir_valid got=%b exp=1", ir_valid); end
    checks++; if (ir !== 16'h1261 || ir_pc !== 16'h3001) begin errors++; $display("FAIL basic_ir got=%h/%h exp=1261/3001", ir, ir_pc); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3001 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL basic_next_req got=%b@%h vld=%b exp=1@3001 vld=0", mem_req, mem_addr, ir_valid); end
    ir_ready = 0;
  endtask

  task automatic test_backpressure;
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h5020; tick();
    mem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (ir_valid !== 1'b1 || ir !== 16'h5020 || ir_pc !== 16'h3002) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b %h/%h exp=1 5020/3002", i, ir_valid, ir, ir_pc); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got=%b exp=0", i, mem_req); end
      tick();
    end
    ir_ready = 1; tick();
    ir_ready = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3002 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got=%b@%h vld=%b exp=1@3002 vld=0", mem_req, mem_addr, ir_valid); end
  endtask

  task automatic test_redirect_outstanding;
    mem_gnt = 1; tick();
    mem_gnt = 0; redirect = 1; redirect_pc = 16'h4000; tick();
    redirect = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin
        errors++; $display("FAIL redir_drain[%0d] got=req%b vld%b exp=req0 vld0", i, mem_req, ir_valid); end
      tick();
    end
    mem_rvalid = 1; mem_rdata = 16'hDEAD; tick();
    mem_rvalid = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h4000 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL redir_restart got=%b@%h vld=%b exp=1@4000 vld=0", mem_req, mem_addr, ir_valid); end
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h0E05; tick();
    mem_rvalid = 0;
    checks++; if (ir === 16'hDEAD) begin errors++; $display("FAIL redir_discard got=%h exp=not DEAD", ir); end
    checks++; if (ir_valid !== 1'b1 || ir !== 16'h0E05 || ir_pc !== 16'h4001) begin
      errors++; $display("FAIL redir_fetch got=%b %h/%h exp=1 0E05/4001", ir_valid, ir, ir_pc); end
    ir_ready = 1; tick();
    ir_ready = 0;
  endtask

  task automatic test_wrap;
    redirect = 1; redirect_pc = 16'hFFFF; tick();
    redirect = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_req got=%b@%h exp=1@FFFF", mem_req, mem_addr); end
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h1234; tick();
    mem_rvalid = 0;
    checks++; if (ir !== 16'h1234 || ir_pc !== 16'h0000) begin errors++; $display("FAIL wrap_ir got=%h/%h exp=1234/0000", ir, ir_pc); end
    ir_ready = 1; tick();
    ir_ready = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next got=%b@%h exp=1@0000", mem_req, mem_addr); end
  endtask

  task automatic test_timeout;
    mem_gnt = 1; tick();
    mem_gnt = 0;
`ifdef LC3_FETCH_TIMEOUT_EN
    repeat (15) tick();
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", fetch_err); end
    tick();
    checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL to_fire got=err%b req%b vld%b exp=err1 req0 vld0", fetch_err, mem_req, ir_valid); end
    mem_rvalid = 1; mem_rdata = 16'h7777; redirect = 1; redirect_pc = 16'h5000; ir_ready = 1; tick();
    idle_inputs(); tick();
    checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0 || mem_addr !== 16'h0001) begin
      errors++; $display("FAIL to_absorb got=err%b req%b vld%b pc%h exp=err1 req0 vld0 pc0001", fetch_err, mem_req, ir_valid, mem_addr); end
`else
    repeat (40) tick();
    checks++; if (fetch_err !== 1'b0 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL to_wait got=err%b req%b vld%b exp=err0 req0 vld0", fetch_err, mem_req, ir_valid); end
    mem_rvalid = 1; mem_rdata = 16'h2FFF; tick();
    mem_rvalid = 0;
    checks++; if (ir_valid !== 1'b1 || ir !== 16'h2FFF || ir_pc !== 16'h0001) begin
      errors++; $display("FAIL to_late got=%b %h/%h exp=1 2FFF/0001", ir_valid, ir, ir_pc); end
    ir_ready = 1; tick();
    ir_ready = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("FAIL to_resume got=%b@%h exp=1@0001", mem_req, mem_addr); end
`endif
  endtask

  // Model tracks fetch order as transactions: expected PC, one pending read, and the word owed to decode.
  task automatic test_random;
    logic [15:0] exp_pc, exp_ir, exp_irpc, pend_pc;
    bit pend, squash, has_exp, first, exp_req, o_req, o_vld;
    int rv_cnt;
    idle_inputs();
    rst_n = 0; tick(); tick(); rst_n = 1;
    exp_pc = 16'h3000; exp_ir = 0; exp_irpc = 0; pend_pc = 0;
    pend = 0; squash = 0; has_exp = 0; first = 1; rv_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_req = first ? 1'b0 : (!pend && !has_exp);
      checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_req); end
      checks++; if (ir_valid !== has_exp) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, ir_valid, has_exp); end
      if (has_exp) begin
        checks++; if (ir !== exp_ir || ir_pc !== exp_irpc) begin
          errors++; $display("FAIL rnd_ir cyc=%0d got=%h/%h exp=%h/%h", cyc, ir, ir_pc, exp_ir, exp_irpc); end
      end
      if (mem_req === 1'b1) begin
        checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_pc); end
      end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", cyc, fetch_err); end

      o_req = (mem_req === 1'b1);
      o_vld = (ir_valid === 1'b1);
      mem_rvalid  = pend && (rv_cnt == 0);
      mem_gnt     = o_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      mem_rdata   = 16'($urandom);
      ir_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);

      if (pend && !mem_rvalid && rv_cnt > 0) rv_cnt--;
      if (redirect) begin
        exp_pc  = redirect_pc;
        has_exp = 0;
        if (pend && mem_rvalid) pend = 0;
        if (pend) squash = 1;
        if (o_req && mem_gnt) begin pend = 1; squash = 1; rv_cnt = $urandom_range(0, 3); end
      end else begin
        if (o_vld && ir_ready) has_exp = 0;
        if (pend && mem_rvalid) begin
          pend = 0;
          if (!squash) begin has_exp = 1; exp_ir = mem_rdata; exp_irpc = pend_pc; end
        end
        if (o_req && mem_gnt) begin
          exp_pc  = exp_pc + 16'd1;
          pend    = 1;
          squash  = 0;
          pend_pc = exp_pc;
          rv_cnt  = $urandom_range(0, 3);
        end
      end
      first = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_outstanding();
    test_wrap();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
